// File: rtl/piso_read_ctrl.sv
// Read sequencer for a 74x165-style parallel-in/serial-out shift register chain.
// Loads the chain, clocks WIDTH bits out on QH and presents them as one word over VALID/READY.
module piso_read_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             BUSY,
  output logic             SH_LD,
  output logic             CLK_INH,
  output logic             SCLK,
  input  logic             QH,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  input  logic             READY
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_HIGH, S_LOW, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_phase;
  logic [BW-1:0]   r_bits;
  logic            w_ph_last;
  logic            w_sample;

  assign w_ph_last = (r_phase == PH_LAST);

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    case (r_state)
      S_IDLE:   if (START) w_next = S_LOAD;
      S_LOAD:   if (w_ph_last) w_next = S_SETTLE;
      S_SETTLE: begin
        if (w_ph_last) begin
          w_sample = 1'b1;
          w_next   = S_HIGH;
        end
      end
      S_HIGH:   if (w_ph_last) w_next = S_LOW;
      S_LOW: begin
        if (w_ph_last) begin
          w_sample = 1'b1;
          // The sample taken now is the last one when WIDTH-1 were already collected.
          w_next   = (r_bits == BIT_LAST) ? S_DONE : S_HIGH;
        end
      end
      S_DONE:   if (READY) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bits  <= '0;
      DATA    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE || r_state == S_DONE || w_ph_last)
        r_phase <= '0;
      else
        r_phase <= r_phase + PW'(1);
      if (r_state == S_IDLE)
        r_bits <= '0;
      else if (w_sample)
        r_bits <= r_bits + BW'(1);
      if (w_sample)
        DATA <= {DATA[WIDTH-2:0], QH};
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SH_LD   <= 1'b1;
      CLK_INH <= 1'b1;
      SCLK    <= 1'b0;
      VALID   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      SH_LD   <= (w_next != S_LOAD);
      CLK_INH <= !(w_next == S_SETTLE || w_next == S_HIGH || w_next == S_LOW);
      SCLK    <= (w_next == S_HIGH);
      VALID   <= (w_next == S_DONE);
      BUSY    <= (w_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_piso_read_ctrl.sv
// Bench for piso_read_ctrl: one 8-bit/DIV=4 instance and one 16-bit/DIV=1 chained instance,
// each driving a behavioural 74x165 chain; a scoreboard checks every presented word.
module tb_piso_read_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // DUT A: WIDTH=8, DIV=4
  logic        start_a = 1'b0, ready_a = 1'b1;
  logic        busy_a, sh_ld_a, clk_inh_a, sclk_a, qh_a, valid_a;
  logic [7:0]  data_a;
  logic [7:0]  pat_a = 8'h00;
  logic [7:0]  sr_a = 8'h00;

  piso_read_ctrl #(.WIDTH(8), .DIV(4)) u_a (
    .CLK(clk), .RST(rst), .START(start_a), .BUSY(busy_a), .SH_LD(sh_ld_a),
    .CLK_INH(clk_inh_a), .SCLK(sclk_a), .QH(qh_a), .DATA(data_a),
    .VALID(valid_a), .READY(ready_a)
  );

  // DUT B: WIDTH=16, DIV=1, two chained devices
  logic        start_b = 1'b0, ready_b = 1'b1;
  logic        busy_b, sh_ld_b, clk_inh_b, sclk_b, qh_b, valid_b;
  logic [15:0] data_b;
  logic [15:0] pat_b = 16'h0000;
  logic [15:0] sr_b = 16'h0000;

  piso_read_ctrl #(.WIDTH(16), .DIV(1)) u_b (
    .CLK(clk), .RST(rst), .START(start_b), .BUSY(busy_b), .SH_LD(sh_ld_b),
    .CLK_INH(clk_inh_b), .SCLK(sclk_b), .QH(qh_b), .DATA(data_b),
    .VALID(valid_b), .READY(ready_b)
  );

  // Behavioural shift-register models: async load while SH_LD low, shift on SCLK rise.
  always @(posedge sclk_a or negedge sh_ld_a)
    if (!sh_ld_a) sr_a <= pat_a;
    else if (!clk_inh_a) sr_a <= {sr_a[6:0], 1'b0};
  assign qh_a = sr_a[7];

  always @(posedge sclk_b or negedge sh_ld_b)
    if (!sh_ld_b) sr_b <= pat_b;
    else if (!clk_inh_b) sr_b <= {sr_b[14:0], 1'b0};
  assign qh_b = sr_b[15];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Activity counters
  int edges_a = 0, inh_bad_a = 0, ld_cyc_a = 0, ld_pulses_a = 0;
  int edges_b = 0, inh_bad_b = 0;

  always @(posedge sclk_a) begin edges_a++; if (clk_inh_a) inh_bad_a++; end
  always @(posedge sclk_b) begin edges_b++; if (clk_inh_b) inh_bad_b++; end
  always @(negedge sh_ld_a) ld_pulses_a++;
  always @(negedge clk) if (!sh_ld_a) ld_cyc_a++;

  // Scoreboards and monitors
  logic [7:0]  exp_a[$];
  logic [15:0] exp_b[$];
  logic        busy_a_q = 1'b0, valid_a_q = 1'b0, busy_b_q = 1'b0, valid_b_q = 1'b0;
  int          st_a = 0, st_b = 0;

  always @(negedge clk) begin
    if (busy_a && !busy_a_q) st_a = cyc;
    if (valid_a && !valid_a_q) begin
      if (exp_a.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        chk("a_data", data_a, exp_a.pop_front());
        chk("a_latency", cyc - st_a, 64);
      end
    end
    busy_a_q  = busy_a;
    valid_a_q = valid_a;
  end

  always @(negedge clk) begin
    if (busy_b && !busy_b_q) st_b = cyc;
    if (valid_b && !valid_b_q) begin
      if (exp_b.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        chk("b_data", data_b, exp_b.pop_front());
        chk("b_latency", cyc - st_b, 32);
      end
    end
    busy_b_q  = busy_b;
    valid_b_q = valid_b;
  end

  // which: 0 = VALID A high, 1 = A idle, 2 = B idle
  task automatic wait_for(input int which, input int lim, input string name);
    bit done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      @(negedge clk);
      case (which)
        0: done = valid_a;
        1: done = !busy_a;
        default: done = !busy_b;
      endcase
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic clr_a();
    edges_a = 0; inh_bad_a = 0; ld_cyc_a = 0; ld_pulses_a = 0;
  endtask

  initial begin
    int gap;
    // Power-on reset values
    repeat (3) @(negedge clk);
    chk("rst_sh_ld", sh_ld_a, 1);
    chk("rst_clk_inh", clk_inh_a, 1);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_data", data_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic read of 0xA5
    clr_a();
    pat_a = 8'hA5; ready_a = 1'b1;
    exp_a.push_back(8'hA5);
    pulse_start_a();
    wait_for(1, 200, "basic_idle");
    chk("basic_ld_cycles", ld_cyc_a, 4);
    chk("basic_sclk_edges", edges_a, 7);
    chk("basic_inh_at_edge", inh_bad_a, 0);

    // Backpressure with 0x3C and ignored STARTs
    clr_a();
    pat_a = 8'h3C; ready_a = 1'b0;
    exp_a.push_back(8'h3C);
    pulse_start_a();
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_for(0, 200, "bp_valid");
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid_hold", valid_a, 1);
      chk("bp_data_hold", data_a, 8'h3C);
      chk("bp_busy", busy_a, 1);
      start_a = (i == 5);
      @(negedge clk);
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    @(negedge clk);
    chk("bp_valid_clear", valid_a, 0);
    chk("bp_idle", busy_a, 0);
    repeat (3) @(negedge clk);
    chk("bp_stays_idle", busy_a, 0);
    chk("bp_ld_pulses", ld_pulses_a, 1);
    chk("bp_ld_cycles", ld_cyc_a, 4);

    // Back-to-back 0x01 then 0x80
    pat_a = 8'h01;
    exp_a.push_back(8'h01);
    exp_a.push_back(8'h80);
    @(negedge clk) start_a = 1'b1;
    wait_for(0, 200, "b2b_valid1");
    pat_a = 8'h80;
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy_a) gap++;
      else break;
    end
    chk("b2b_idle_gap", gap, 1);
    wait_for(0, 200, "b2b_valid2");
    start_a = 1'b0;
    wait_for(1, 20, "b2b_idle");

    // Reset after the 4th sample, then a full read of 0xFF
    pat_a = 8'h5A;
    pulse_start_a();
    repeat (34) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sh_ld", sh_ld_a, 1);
    chk("mid_rst_clk_inh", clk_inh_a, 1);
    chk("mid_rst_sclk", sclk_a, 0);
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_data", data_a, 0);
    @(negedge clk) rst = 1'b0;
    clr_a();
    pat_a = 8'hFF;
    exp_a.push_back(8'hFF);
    pulse_start_a();
    wait_for(1, 200, "post_rst_idle");
    chk("post_rst_sclk_edges", edges_a, 7);

    // Chained 16-bit read, DIV=1
    pat_b = 16'hBEEF;
    exp_b.push_back(16'hBEEF);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    wait_for(2, 100, "chain_idle");
    chk("chain_sclk_edges", edges_b, 15);
    chk("chain_inh_at_edge", inh_bad_b, 0);

    repeat (3) @(negedge clk);
    chk("sb_a_drained", exp_a.size(), 0);
    chk("sb_b_drained", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
